// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the returned word into the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        pc_oob,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Priority below reset: redirect > stall > advance.
    always_comb begin
        pc_d         = pc_q;
        valid_d      = valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        misalign_d   = misalign_q;
        count_d      = count_q;
        if (redirect_valid) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            valid_d      = 1'b0;
            ifid_pc_d    = '0;
            ifid_pc4_d   = '0;
            ifid_instr_d = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d         = pc_plus4;
            valid_d      = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_instr;
            if (count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            misalign_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            misalign_q   <= misalign_d;
            count_q      <= count_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_valid    = valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc4_q;
    assign ifid_instr    = ifid_instr_q;
    assign misalign_err  = misalign_q;
    assign fetch_count   = count_q;
    // Any address bit above the memory window set means the memory is aliasing.
    assign pc_oob        = (pc_q >> (IMEM_WORDS_LOG2 + 2)) != 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic        pc_oob;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[11:2]];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_instr     (ifid_instr),
        .pc_oob         (pc_oob),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] word_at(input int idx);
        if (idx == 0) return 32'h3C10_0000;
        if (idx == 1) return 32'h3610_0000;
        return 32'hA500_0000 | 32'(idx);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_at(i);

        // Reset state
        step();
        step();
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", 32'(ifid_valid), 32'h0);
        check_eq("rst_instr", ifid_instr, 32'h0);
        check_eq("rst_pc", ifid_pc, 32'h0);
        check_eq("rst_count", fetch_count, 32'h0);
        check_eq("rst_misalign", 32'(misalign_err), 32'h0);

        // Free run
        reset = 1'b0;
        step();
        check_eq("c1_valid", 32'(ifid_valid), 32'h1);
        check_eq("c1_pc", ifid_pc, 32'h0);
        check_eq("c1_instr", ifid_instr, 32'h3C10_0000);
        check_eq("c1_pc4", ifid_pc_plus4, 32'h4);
        check_eq("c1_addr", imem_addr, 32'h4);
        step();
        check_eq("c2_pc", ifid_pc, 32'h4);
        check_eq("c2_instr", ifid_instr, 32'h3610_0000);
        check_eq("c2_count", fetch_count, 32'd2);
        step();
        check_eq("c3_pc", ifid_pc, 32'h8);
        check_eq("c3_addr", imem_addr, 32'hC);

        // Stall for three cycles
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stall_pc", ifid_pc, 32'h8);
            check_eq("stall_addr", imem_addr, 32'hC);
            check_eq("stall_count", fetch_count, 32'd3);
            check_eq("stall_instr", ifid_instr, word_at(2));
        end
        stall = 1'b0;
        step();
        check_eq("post_stall_pc", ifid_pc, 32'hC);
        check_eq("post_stall_instr", ifid_instr, word_at(3));
        check_eq("post_stall_count", fetch_count, 32'd4);

        // Run up to PC 0x78, then redirect to 0x24
        repeat (26) step();
        check_eq("at78_addr", imem_addr, 32'h78);
        check_eq("at78_oob", 32'(pc_oob), 32'h0);
        check_eq("at78_count", fetch_count, 32'd30);
        redirect_valid = 1'b1;
        redirect_pc = 32'h24;
        step();
        redirect_valid = 1'b0;
        check_eq("rd_valid", 32'(ifid_valid), 32'h0);
        check_eq("rd_instr", ifid_instr, 32'h0);
        check_eq("rd_addr", imem_addr, 32'h24);
        check_eq("rd_count", fetch_count, 32'd30);
        step();
        check_eq("rd2_pc", ifid_pc, 32'h24);
        check_eq("rd2_valid", 32'(ifid_valid), 32'h1);
        check_eq("rd2_instr", ifid_instr, word_at(9));
        check_eq("rd2_pc4", ifid_pc_plus4, 32'h28);

        // Redirect with simultaneous stall
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        stall = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check_eq("rs_addr", imem_addr, 32'h40);
        check_eq("rs_valid", 32'(ifid_valid), 32'h0);
        check_eq("rs_count", fetch_count, 32'd31);
        step();
        check_eq("rs2_pc", ifid_pc, 32'h40);
        check_eq("rs2_count", fetch_count, 32'd32);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        check_eq("mis_addr", imem_addr, 32'h100);
        check_eq("mis_flag", 32'(misalign_err), 32'h1);
        step();
        check_eq("mis_sticky", 32'(misalign_err), 32'h1);
        check_eq("mis_pc", ifid_pc, 32'h100);
        check_eq("mis_instr", ifid_instr, word_at(32'h40));

        // Out-of-range boundary at the top of the window
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFC;
        step();
        redirect_valid = 1'b0;
        check_eq("oob_ffc", 32'(pc_oob), 32'h0);
        step();
        check_eq("oob_1000_addr", imem_addr, 32'h1000);
        check_eq("oob_1000", 32'(pc_oob), 32'h1);
        check_eq("oob_count", fetch_count, 32'd34);

        // Wrap from the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check_eq("wrap_oob", 32'(pc_oob), 32'h1);
        step();
        check_eq("wrap_addr0", imem_addr, 32'h0);
        check_eq("wrap_oob0", 32'(pc_oob), 32'h0);
        check_eq("wrap_ifpc", ifid_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", ifid_pc_plus4, 32'h0);
        check_eq("wrap_instr", ifid_instr, word_at(1023));
        check_eq("wrap_count", fetch_count, 32'd35);
        check_eq("wrap_misalign", 32'(misalign_err), 32'h1);

        // Reset during a stall
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        check_eq("rs_mid_addr", imem_addr, 32'h0);
        check_eq("rs_mid_valid", 32'(ifid_valid), 32'h0);
        check_eq("rs_mid_count", fetch_count, 32'h0);
        check_eq("rs_mid_misalign", 32'(misalign_err), 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        check_eq("rs_mid_run_pc", ifid_pc, 32'h0);
        check_eq("rs_mid_run_count", fetch_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
